// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared types and elaboration-time helpers for the video timing generator.
//   timing_t        : aligned timing bundle {hb, vb, hs, vs, ls, fs}, all
//                     active-high (sync polarity is applied at the outputs).
//   TIMING_IDLE     : blank/inactive value used for reset of the delay line.
//   span_total()    : active + porches + sync, i.e. H_TOTAL / V_TOTAL.
//   sync_lo/hi()    : clamp bounds for the sync start position.
//   clamp_sync_start: nominal sync start plus a signed 4-bit shift, clamped.
// -----------------------------------------------------------------------------
package video_timing_pkg;

    typedef struct packed {
        logic hb;   // horizontal blank
        logic vb;   // vertical blank
        logic hs;   // horizontal sync, active-high
        logic vs;   // vertical sync, active-high
        logic ls;   // first pixel of a line
        logic fs;   // first pixel of a frame
    } timing_t;

    localparam int TIMING_W = $bits(timing_t);

    localparam timing_t TIMING_IDLE = '{hb: 1'b1, vb: 1'b1, hs: 1'b0,
                                        vs: 1'b0, ls: 1'b0, fs: 1'b0};

    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Sync may not start inside the active region.
    function automatic int sync_lo(input int active);
        return active;
    endfunction

    // Sync must end no later than the last count of the line/frame.
    function automatic int sync_hi(input int total, input int sync);
        return total - sync;
    endfunction

    function automatic int clamp_sync_start(input int nominal,
                                            input logic signed [3:0] ofs,
                                            input int lo, input int hi);
        int s;
        s = nominal + int'(ofs);
        if (s < lo) s = lo;
        if (s > hi) s = hi;
        return s;
    endfunction

endpackage

// File: rtl/timing_delay_line.sv
// -----------------------------------------------------------------------------
// timing_delay_line
// DEPTH-stage shift register of timing_t words, advanced only on ce. Lines up
// the decoded raster timing with the game core's pixel pipeline.
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset (all stages -> TIMING_IDLE)
//   ce         in   shift enable (pixel clock enable)
//   din        in   raw timing word for the pixel currently presented
//   tail_q     out  registered last stage (aligned timing)
//   tail_blank out  blank flag of the word being shifted into the last stage,
//                   so the pixel register can mask on the same ce
// -----------------------------------------------------------------------------
module timing_delay_line
    import video_timing_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [TIMING_W-1:0] din,
    output logic [TIMING_W-1:0] tail_q,
    output logic                tail_blank
);

    logic [TIMING_W-1:0] stage_q [DEPTH];
    timing_t             pre_tail;

    // NOTE: this is a handful of flops, not a RAM, so every stage is reset;
    // otherwise the first PIX_LAT ticks after reset would show stale sync.
    // NOTE: sequential state uses non-blocking assignments so each stage
    // samples its neighbour's pre-edge value and the chain shifts by one.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= TIMING_IDLE;
        end else if (ce) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    if (DEPTH == 1) begin : g_single
        assign pre_tail = timing_t'(din);
    end else begin : g_multi
        assign pre_tail = timing_t'(stage_q[DEPTH-2]);
    end

    assign tail_q     = stage_q[DEPTH-1];
    assign tail_blank = pre_tail.hb | pre_tail.vb;

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster counter for one arcade core in the clk_sys domain.
// Exports hpos/vpos to the game core, delays the decoded blank/sync by PIX_LAT
// pixel ticks so they line up with rgb_in, and drives blank-masked RGB, DE and
// line/frame strobes to the video chain.
// Optional feature macro: VIDEO_TIMING_GEN_OFFSET_EN
//   defined   : h_ofs / v_ofs (signed) shift the sync start, sampled once per
//               frame at hcnt == 0 && vcnt == 0 and clamped to the porch area.
//   undefined : h_ofs / v_ofs are ignored and no offset registers exist.
// Ports:
//   clk_sys     in   system clock
//   reset_n     in   asynchronous active-low reset
//   ce_pix      in   pixel clock enable, one clk_sys cycle wide
//   h_ofs/v_ofs in   signed 4-bit sync shifts
//   rgb_in      in   pixel from the game core, valid PIX_LAT ticks after hpos
//   hpos/vpos   out  current counters (combinational)
//   rgb_out     out  pixel, forced to 0 while the aligned blank is set
//   hblank/vblank/hsync/vsync/de  out  aligned timing
//   line_start/frame_start        out  one-clk_sys strobes on the first
//                                      aligned pixel of a line / frame
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW       = 9,
    parameter int RGB_W    = 12,
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 23,
    parameter int H_SYNC   = 31,
    parameter int H_BP     = 42,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 29,
    parameter int PIX_LAT  = 1,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [3:0]       h_ofs,
    input  logic [3:0]       v_ofs,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CW-1:0]    hpos,
    output logic [CW-1:0]    vpos,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS0_NOM = H_ACTIVE + H_FP;
    localparam int VS0_NOM = V_ACTIVE + V_FP;
    localparam int HS0_MIN = sync_lo(H_ACTIVE);
    localparam int HS0_MAX = sync_hi(H_TOTAL, H_SYNC);
    localparam int VS0_MIN = sync_lo(V_ACTIVE);
    localparam int VS0_MAX = sync_hi(V_TOTAL, V_SYNC);

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (PIX_LAT < 1 || PIX_LAT > 8) begin : g_bad_lat
        $error("video_timing_gen: PIX_LAT must be 1..8");
    end

    // All position arithmetic is done one bit wider than the counters so that
    // sync_start + sync_width never wraps.
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW:0]   HA_X    = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   VA_X    = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   HSW_X   = (CW+1)'(H_SYNC);
    localparam logic [CW:0]   VSW_X   = (CW+1)'(V_SYNC);

    logic [CW-1:0]       hcnt, vcnt;
    logic [CW:0]         hc_x, vc_x;
    logic [CW:0]         hs0, vs0;
    timing_t             raw;
    timing_t             aligned;
    logic [TIMING_W-1:0] tail_vec;
    logic                tail_blank;
    logic                ce_d;
    logic                frame_origin;

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce_pix) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign hpos         = hcnt;
    assign vpos         = vcnt;
    assign hc_x         = {1'b0, hcnt};
    assign vc_x         = {1'b0, vcnt};
    assign frame_origin = (hcnt == '0) && (vcnt == '0);

    // ------------------------------------------------------------ sync start
`ifdef VIDEO_TIMING_GEN_OFFSET_EN
    // The shifted sync start is captured only at the frame origin so that a
    // change on h_ofs/v_ofs never splits a frame between two positions.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs0 <= (CW+1)'(HS0_NOM);
            vs0 <= (CW+1)'(VS0_NOM);
        end else if (ce_pix && frame_origin) begin
            hs0 <= (CW+1)'(clamp_sync_start(HS0_NOM, h_ofs, HS0_MIN, HS0_MAX));
            vs0 <= (CW+1)'(clamp_sync_start(VS0_NOM, v_ofs, VS0_MIN, VS0_MAX));
        end
    end
`else
    logic unused_ofs;

    assign hs0        = (CW+1)'(HS0_NOM);
    assign vs0        = (CW+1)'(VS0_NOM);
    assign unused_ofs = ^{h_ofs, v_ofs};
`endif

    // ------------------------------------------------------------ raw decode
    // vs depends on vcnt only, and vcnt changes only on the hcnt wrap, so
    // vertical sync edges always fall on hcnt == 0.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        raw    = TIMING_IDLE;
        raw.hb = (hc_x >= HA_X);
        raw.vb = (vc_x >= VA_X);
        raw.hs = (hc_x >= hs0) && (hc_x < hs0 + HSW_X);
        raw.vs = (vc_x >= vs0) && (vc_x < vs0 + VSW_X);
        raw.ls = (hcnt == '0);
        raw.fs = frame_origin;
    end

    // ------------------------------------------------------------- alignment
    timing_delay_line #(
        .DEPTH (PIX_LAT)
    ) u_delay (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce         (ce_pix),
        .din        (raw),
        .tail_q     (tail_vec),
        .tail_blank (tail_blank)
    );

    assign aligned = timing_t'(tail_vec);

    // rgb_in is sampled on the same ce that loads the aligned word, so the
    // mask uses the word entering the tail rather than the current tail.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out <= '0;
        end else if (ce_pix) begin
            rgb_out <= tail_blank ? '0 : rgb_in;
        end
    end

    // ce_d marks the single clk_sys cycle after a pixel tick; qualifying the
    // aligned ls/fs with it turns them into one-cycle strobes even when
    // ce_pix is held high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce_d <= 1'b0;
        end else begin
            ce_d <= ce_pix;
        end
    end

    assign hblank      = aligned.hb;
    assign vblank      = aligned.vb;
    assign hsync       = (HS_POL != 0) ? aligned.hs : ~aligned.hs;
    assign vsync       = (VS_POL != 0) ? aligned.vs : ~aligned.vs;
    assign de          = ~(aligned.hb | aligned.vb);
    assign line_start  = aligned.ls & ce_d;
    assign frame_start = aligned.fs & ce_d;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Two instances share all inputs:
//   dut_a : default 384x263 raster, PIX_LAT = 1, active-low syncs.
//   dut_b : small 28x13 raster, PIX_LAT = 3, active-high hsync, so whole
//           frames, vertical sync and offset clamping fit in a short run.
// The reference model counts pixel ticks since reset and derives every
// expected output from that count with division/modulo.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_pix  = 1'b0;
    logic [3:0]  h_ofs   = '0;
    logic [3:0]  v_ofs   = '0;
    logic [11:0] rgb_in  = '0;

    logic [8:0]  a_hpos, a_vpos;
    logic [11:0] a_rgb;
    logic        a_hblank, a_vblank, a_hsync, a_vsync, a_de, a_ls, a_fs;
    logic [4:0]  b_hpos, b_vpos;
    logic [11:0] b_rgb;
    logic        b_hblank, b_vblank, b_hsync, b_vsync, b_de, b_ls, b_fs;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_sys = ~clk_sys;

    video_timing_gen dut_a (
        .clk_sys (clk_sys), .reset_n (reset_n), .ce_pix (ce_pix),
        .h_ofs (h_ofs), .v_ofs (v_ofs), .rgb_in (rgb_in),
        .hpos (a_hpos), .vpos (a_vpos), .rgb_out (a_rgb),
        .hblank (a_hblank), .vblank (a_vblank), .hsync (a_hsync),
        .vsync (a_vsync), .de (a_de), .line_start (a_ls), .frame_start (a_fs)
    );

    video_timing_gen #(
        .CW (5), .RGB_W (12),
        .H_ACTIVE (16), .H_FP (3), .H_SYNC (4), .H_BP (5),
        .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .PIX_LAT (3), .HS_POL (1), .VS_POL (0)
    ) dut_b (
        .clk_sys (clk_sys), .reset_n (reset_n), .ce_pix (ce_pix),
        .h_ofs (h_ofs), .v_ofs (v_ofs), .rgb_in (rgb_in),
        .hpos (b_hpos), .vpos (b_vpos), .rgb_out (b_rgb),
        .hblank (b_hblank), .vblank (b_vblank), .hsync (b_hsync),
        .vsync (b_vsync), .de (b_de), .line_start (b_ls), .frame_start (b_fs)
    );

    // ------------------------------------------------------------ model data
    int m_ha  [2] = '{288, 16};
    int m_hfp [2] = '{23, 3};
    int m_hsw [2] = '{31, 4};
    int m_hbp [2] = '{42, 5};
    int m_va  [2] = '{224, 6};
    int m_vfp [2] = '{3, 2};
    int m_vsw [2] = '{7, 2};
    int m_vbp [2] = '{29, 3};
    int m_lat [2] = '{1, 3};
    int m_hpol[2] = '{0, 1};
    int m_vpol[2] = '{0, 0};

    int          m_t   [2];
    int          m_hs0 [2][256];
    int          m_vs0 [2][256];
    bit          m_hb  [2];
    bit          m_vb  [2];
    bit          m_hs  [2];
    bit          m_vs  [2];
    bit          m_ls  [2];
    bit          m_fs  [2];
    logic [11:0] m_rgb [2];

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time,
                     actual, expected);
        end
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_t[d]   = 0;
            m_hb[d]  = 1'b1;
            m_vb[d]  = 1'b1;
            m_hs[d]  = 1'b0;
            m_vs[d]  = 1'b0;
            m_ls[d]  = 1'b0;
            m_fs[d]  = 1'b0;
            m_rgb[d] = '0;
        end
    endtask

    // One clk_sys edge with the given inputs.
    task automatic model_edge(input bit ce, input logic [11:0] rgb,
                              input int hofs, input int vofs);
        int ht, vt, ft, p, h, v, f;
        for (int d = 0; d < 2; d++) begin
            ht = m_ha[d] + m_hfp[d] + m_hsw[d] + m_hbp[d];
            vt = m_va[d] + m_vfp[d] + m_vsw[d] + m_vbp[d];
            ft = ht * vt;
            m_ls[d] = 1'b0;
            m_fs[d] = 1'b0;
            if (ce) begin
                if (m_t[d] % ft == 0) begin
                    f = (m_t[d] / ft) % 256;
`ifdef VIDEO_TIMING_GEN_OFFSET_EN
                    m_hs0[d][f] = clampi(m_ha[d] + m_hfp[d] + hofs, m_ha[d], ht - m_hsw[d]);
                    m_vs0[d][f] = clampi(m_va[d] + m_vfp[d] + vofs, m_va[d], vt - m_vsw[d]);
`else
                    m_hs0[d][f] = m_ha[d] + m_hfp[d] + 0 * hofs;
                    m_vs0[d][f] = m_va[d] + m_vfp[d] + 0 * vofs;
`endif
                end
                m_t[d]++;
                p = m_t[d] - m_lat[d];
                if (p >= 0) begin
                    h = p % ht;
                    v = (p / ht) % vt;
                    f = (p / ft) % 256;
                    m_hb[d]  = (h >= m_ha[d]);
                    m_vb[d]  = (v >= m_va[d]);
                    m_hs[d]  = (h >= m_hs0[d][f]) && (h < m_hs0[d][f] + m_hsw[d]);
                    m_vs[d]  = (v >= m_vs0[d][f]) && (v < m_vs0[d][f] + m_vsw[d]);
                    m_rgb[d] = (m_hb[d] || m_vb[d]) ? 12'h000 : rgb;
                    m_ls[d]  = (h == 0);
                    m_fs[d]  = (h == 0) && (v == 0);
                end else begin
                    m_rgb[d] = '0;
                end
            end
        end
    endtask

    function automatic logic [6:0] exp_ctl(input int d);
        logic hs_lvl, vs_lvl;
        hs_lvl = (m_hpol[d] != 0) ? m_hs[d] : !m_hs[d];
        vs_lvl = (m_vpol[d] != 0) ? m_vs[d] : !m_vs[d];
        return {m_hb[d], m_vb[d], hs_lvl, vs_lvl, !(m_hb[d] || m_vb[d]),
                m_ls[d], m_fs[d]};
    endfunction

    task automatic compare_all();
        int ht, vt;
        ht = m_ha[0] + m_hfp[0] + m_hsw[0] + m_hbp[0];
        vt = m_va[0] + m_vfp[0] + m_vsw[0] + m_vbp[0];
        check("a_hpos", 32'(a_hpos), 32'(m_t[0] % ht));
        check("a_vpos", 32'(a_vpos), 32'((m_t[0] / ht) % vt));
        check("a_rgb",  32'(a_rgb),  32'(m_rgb[0]));
        check("a_ctl",  32'({a_hblank, a_vblank, a_hsync, a_vsync, a_de, a_ls, a_fs}),
              32'(exp_ctl(0)));
        ht = m_ha[1] + m_hfp[1] + m_hsw[1] + m_hbp[1];
        vt = m_va[1] + m_vfp[1] + m_vsw[1] + m_vbp[1];
        check("b_hpos", 32'(b_hpos), 32'(m_t[1] % ht));
        check("b_vpos", 32'(b_vpos), 32'((m_t[1] / ht) % vt));
        check("b_rgb",  32'(b_rgb),  32'(m_rgb[1]));
        check("b_ctl",  32'({b_hblank, b_vblank, b_hsync, b_vsync, b_de, b_ls, b_fs}),
              32'(exp_ctl(1)));
    endtask

    // ce modes: 0 every 4th cycle, 1 random, 2 always, 3 never.
    // ofs_mode: 0 fixed (hofs/vofs), 1 random value every ~64 cycles.
    task automatic run_phase(input int cycles, input int ce_mode,
                             input int hofs, input int vofs, input int ofs_mode);
        bit          ce;
        logic [11:0] rgb;
        int          ho, vo;
        ho = hofs;
        vo = vofs;
        for (int c = 0; c < cycles; c++) begin
            case (ce_mode)
                0:       ce = (c % 4 == 0);
                1:       ce = ($urandom_range(0, 1) == 1);
                2:       ce = 1'b1;
                default: ce = 1'b0;
            endcase
            if (ofs_mode == 1 && $urandom_range(0, 63) == 0) begin
                ho = $urandom_range(0, 15) - 8;
                vo = $urandom_range(0, 15) - 8;
            end
            rgb    = 12'($urandom);
            ce_pix = ce;
            rgb_in = rgb;
            h_ofs  = 4'(ho);
            v_ofs  = 4'(vo);
            model_edge(ce, rgb, ho, vo);
            @(negedge clk_sys);
            compare_all();
        end
    endtask

    // Reset asserted between edges; outputs must change without a clock edge.
    task automatic mid_line_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int c = 0; c < 3; c++) begin
            ce_pix = ($urandom_range(0, 1) == 1);
            rgb_in = 12'($urandom);
            @(negedge clk_sys);
            compare_all();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_sys);
        compare_all();
        reset_n = 1'b1;

        run_phase(4000, 0,  0,  0, 0);   // ce every 4th clk, no offsets
        run_phase(1500, 1, -5,  0, 0);   // offset changed mid-frame
        run_phase(3000, 2,  7, -8, 0);   // continuous ce, clamped v offset
        run_phase(100,  3,  7, -8, 0);   // ce held low: everything frozen
        run_phase(2000, 2, -8,  7, 0);
        run_phase(37,   1,  0,  0, 0);   // land somewhere mid-line
        mid_line_reset();
        run_phase(1000, 2,  0,  0, 0);   // first frame after reset release
        run_phase(6000, 1,  0,  0, 1);   // random ce and offsets
        run_phase(2000, 0,  3, -3, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
